phat_sinh_chuoi: RTL
====================

Name: phat_sinh_chuoi

Overview:
- Serial pattern generator. Registered 1-bit stream `w` drives the serial input of the team's sequence detectors (e.g. the 1111 detector) in loopback and system test.
- Latches a PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with a fixed gap of zeros between repeats, then pulses `done`.

Parameters:
- PAT_W, 8, pattern width in bits (>=2)
- CNT_W, 4, width of the repeat-count input
- GAP_LEN, 2, number of w=0 cycles inserted between repeats (0 allowed)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rs  input  1  reset, synchronous, active-high
- start  input  1  transmit request; sampled only in IDLE
- pattern  input  PAT_W  pattern to send; latched on accepted start
- repeat_n  input  CNT_W  number of transmissions; latched on accepted start; 0 treated as 1
- w  output  1  serial data, registered
- valid  output  1  high while w carries a pattern bit
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  one-cycle pulse after the final bit

Behaviour:
- Reset: rs=1 at a clock edge forces state=IDLE, w=0, valid=0, busy=0, done=0, and clears the shift register and counters.
  - rs has priority over all other inputs.
  - Mid-transmission reset aborts immediately; no done pulse.
- All outputs are registered (Moore). They are a function of state/datapath only, never combinational from inputs.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - w=0, valid=0, busy=0.
  - On start=1: latch pattern into shift reg sr, latch rep=max(repeat_n,1), bit_cnt=PAT_W-1, go to SHIFT.
- SHIFT:
  - w=sr[PAT_W-1], valid=1, busy=1. First bit appears the cycle after start is sampled (latency 1).
  - Each cycle: sr shifts left by 1 (reload copy keeps the original pattern), bit_cnt decrements.
  - When bit_cnt==0 (last bit on w), rep decrements.
    - If rep (before decrement) >1 and GAP_LEN>0: go to GAP.
    - If rep >1 and GAP_LEN=0: reload sr and stay in SHIFT (back-to-back, no bubble).
    - If rep ==1: go to DONE.
- GAP:
  - w=0, valid=0, busy=1 for exactly GAP_LEN cycles (gap counter).
  - Then reload sr from the saved pattern, bit_cnt=PAT_W-1, go to SHIFT.
- DONE:
  - w=0, valid=0, busy=1, done=1 for one cycle, then IDLE.
  - A new start is accepted at the earliest on the cycle after DONE.
- start while busy is ignored, not queued. pattern and repeat_n changes while busy have no effect.
- Total cycles from the start-sample edge to the done pulse: rep*PAT_W + (rep-1)*GAP_LEN + 1.
- Counter widths:
  - bit_cnt: clog2(PAT_W) bits.
  - rep: CNT_W bits.
  - gap counter: clog2(GAP_LEN+1) bits, minimum 1.
  - No wrap-around is reachable in legal operation.
- Undefined state encodings recover to IDLE with outputs 0.

Decomposition:
- Shared package phat_hien_pkg holds:
  - state constants S_IDLE=0, S_SHIFT=1, S_GAP=2, S_DONE=3 (2-bit state type);
  - the default PAT_W/CNT_W/GAP_LEN values, shared with the detector benches.
- One natural sub-module, thanh_ghi_dich_nap: a loadable PAT_W-bit left-shift register with load/shift enables and MSB output. The FSM, counters and output registers stay in the top module.

Test Plan:
- Basic send: rs pulse, then pattern=8'h0F, repeat_n=1, start for one cycle.
  - Next 8 cycles: w=0,0,0,0,1,1,1,1 with valid=1.
  - Cycle 9 after start: done=1. Cycle 10: busy=0.
- Repeat with gap: pattern=8'hF0, repeat_n=2, GAP_LEN=2.
  - w=11110000, then 00 with valid=0, then 11110000.
  - done on cycle 19. Loopback to the 1111 detector: y=1 exactly twice.
- Back-to-back: GAP_LEN=0, pattern=8'hFF, repeat_n=3.
  - 24 consecutive w=1 with valid=1, done at cycle 25.
  - Detector y stays high from its 4th one through the last.
- Ignored start: start pulsed again during SHIFT with pattern=8'h00. The stream is unchanged and exactly one done pulse occurs.
- Reset mid-op: rs=1 during bit 3 of 8'hAA.
  - Next cycle: w=0, valid=0, busy=0, no done.
  - A fresh start afterwards sends the full 8'hAA correctly.
- repeat_n=0 with pattern=8'h81: exactly one transmission (1,0,0,0,0,0,0,1), done at cycle 9.

Source files
------------

// File: rtl/phat_hien_pkg.sv
// Shared definitions for the serial pattern generator and the sequence detector benches.
package phat_hien_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_PAT_W   = 8;
    localparam int unsigned DEF_CNT_W   = 4;
    localparam int unsigned DEF_GAP_LEN = 2;

endpackage

// File: rtl/thanh_ghi_dich_nap.sv
// Loadable left-shift register; the MSB is the next bit to be sent.
module thanh_ghi_dich_nap
    import phat_hien_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [PAT_W-1:0] data_i,
    output logic             msb_o
);

    logic [PAT_W-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (rs) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[PAT_W-2:0], 1'b0};
        end
    end

    assign msb_o = sr_q[PAT_W-1];

endmodule

// File: rtl/phat_sinh_chuoi.sv
// Serial pattern generator: sends a latched pattern MSB-first, repeated with zero gaps, then pulses done.
module phat_sinh_chuoi
    import phat_hien_pkg::*;
#(
    parameter int unsigned PAT_W   = DEF_PAT_W,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned GAP_LEN = DEF_GAP_LEN
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             w,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W    = $clog2(PAT_W);
    localparam int unsigned GAP_W    = (GAP_LEN < 1) ? 1 : $clog2(GAP_LEN + 1);
    localparam int unsigned GAP_LOAD = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

    state_e           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             w_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic             sr_load;
    logic             sr_shift;
    logic [PAT_W-1:0] sr_din;
    logic             sr_msb;

    // The shift register holds the bits still to come; the current bit already sits in w_q.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_din   = {pat_q[PAT_W-2:0], 1'b0};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_load = 1'b1;
                    sr_din  = {pattern[PAT_W-2:0], 1'b0};
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    sr_shift = 1'b1;
                end else if ((rep_q > CNT_W'(1)) && (GAP_LEN == 0)) begin
                    sr_load = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    sr_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    thanh_ghi_dich_nap #(
        .PAT_W (PAT_W)
    ) u_sr (
        .clk     (clk),
        .rs      (rs),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (sr_din),
        .msb_o   (sr_msb)
    );

    always_ff @(posedge clk) begin
        if (rs) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            gap_cnt_q <= '0;
            w_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    w_q     <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        state_q   <= S_SHIFT;
                        pat_q     <= pattern;
                        rep_q     <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                        bit_cnt_q <= BIT_W'(PAT_W - 1);
                        w_q       <= pattern[PAT_W-1];
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt_q != '0) begin
                        bit_cnt_q <= bit_cnt_q - BIT_W'(1);
                        w_q       <= sr_msb;
                    end else begin
                        rep_q <= rep_q - CNT_W'(1);
                        if (rep_q > CNT_W'(1)) begin
                            if (GAP_LEN > 0) begin
                                state_q   <= S_GAP;
                                gap_cnt_q <= GAP_W'(GAP_LOAD);
                                w_q       <= 1'b0;
                                valid_q   <= 1'b0;
                            end else begin
                                bit_cnt_q <= BIT_W'(PAT_W - 1);
                                w_q       <= pat_q[PAT_W-1];
                            end
                        end else begin
                            state_q <= S_DONE;
                            w_q     <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q   <= S_SHIFT;
                        bit_cnt_q <= BIT_W'(PAT_W - 1);
                        w_q       <= pat_q[PAT_W-1];
                        valid_q   <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    w_q     <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    w_q     <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign w     = w_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
